evklid_mod_inv: RTL and testbench

//  Sequential modular-inverse engine: data_o = data_i^-1 mod gf via iterative extended Euclid.

---
 rtl/evklid_pkg.sv | 32 +++
 rtl/evklid_mod_inv_div.sv | 97 +++++++++
 rtl/evklid_mod_inv.sv | 194 +++++++++++++++++++
 tb/tb_evklid_mod_inv.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/evklid_pkg.sv
// -----------------------------------------------------------------------------
// evklid_pkg
//   Shared types and helpers for the extended-Euclid inverse engine and future
//   inverse/division blocks built on the same sequencer.
//   - state_t    : sequencer states IDLE, CHECK, DIV, UPD, FIX
//   - fn_mod_fix : maps a signed Bezout coefficient t (|t| <= m) onto the
//                  residue range [0, m-1] by adding m once when t is negative.
//                  Operates on 32-bit carriers so it has no width parameters;
//                  callers sign-extend into it and size-cast the result back.
// -----------------------------------------------------------------------------
package evklid_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    DIV   = 3'd2,
    UPD   = 3'd3,
    FIX   = 3'd4
  } state_t;

  function automatic logic [31:0] fn_mod_fix(input logic signed [31:0] t,
                                             input logic        [31:0] m);
    logic [31:0] res;
    if (t < 32'sd0) begin
      res = $unsigned(t) + m;
    end else begin
      res = $unsigned(t);
    end
    return res;
  endfunction

endpackage

// File: rtl/evklid_mod_inv_div.sv
// -----------------------------------------------------------------------------
// evklid_div
//   Restoring shift-subtract divider, one quotient bit per clock.
//   The first bit is produced on the start edge itself, so done pulses exactly
//   DATA_WIDTH cycles after the cycle in which start is high. quo/rem hold
//   their values until the next start. den is never zero (guaranteed by the
//   caller). DATA_WIDTH must be at least 2.
// Ports
//   clk    in   1           clock, rising edge
//   rst_n  in   1           async active-low reset (aborts a division)
//   start  in   1           load num/den and begin
//   num    in   DATA_WIDTH  dividend
//   den    in   DATA_WIDTH  divisor (non-zero)
//   done   out  1           one-cycle pulse, quo/rem valid from this cycle
//   quo    out  DATA_WIDTH  quotient
//   rem    out  DATA_WIDTH  remainder
// -----------------------------------------------------------------------------
module evklid_div #(
  parameter int DATA_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] num,
  input  logic [DATA_WIDTH-1:0] den,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quo,
  output logic [DATA_WIDTH-1:0] rem
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic [CW-1:0]         cnt_r;
  logic [DATA_WIDTH-1:0] rem_r;
  logic [DATA_WIDTH-1:0] quo_r;
  logic [DATA_WIDTH-1:0] den_r;
  logic                  done_r;

  logic [DATA_WIDTH-1:0] step_rem_in_s;
  logic [DATA_WIDTH-1:0] step_quo_in_s;
  logic [DATA_WIDTH-1:0] step_den_s;
  logic [DATA_WIDTH:0]   shifted_s;
  logic                  fits_s;
  logic [DATA_WIDTH-1:0] step_rem_s;
  logic [DATA_WIDTH-1:0] step_quo_s;

  // One restoring step; on start it works straight from the fresh operands.
  always_comb begin
    if (start) begin
      step_rem_in_s = {DATA_WIDTH{1'b0}};
      step_quo_in_s = num;
      step_den_s    = den;
    end else begin
      step_rem_in_s = rem_r;
      step_quo_in_s = quo_r;
      step_den_s    = den_r;
    end
    shifted_s = {step_rem_in_s, step_quo_in_s[DATA_WIDTH-1]};
    fits_s    = (shifted_s >= {1'b0, step_den_s});
    if (fits_s) begin
      step_rem_s = DATA_WIDTH'(shifted_s - {1'b0, step_den_s});
    end else begin
      step_rem_s = shifted_s[DATA_WIDTH-1:0];
    end
    // The dividend shifts out of quo while quotient bits shift in.
    step_quo_s = {step_quo_in_s[DATA_WIDTH-2:0], fits_s};
  end

  // Divider state: load on start, then DATA_WIDTH-1 further steps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= {CW{1'b0}};
      rem_r  <= {DATA_WIDTH{1'b0}};
      quo_r  <= {DATA_WIDTH{1'b0}};
      den_r  <= {DATA_WIDTH{1'b0}};
      done_r <= 1'b0;
    end else if (start) begin
      rem_r  <= step_rem_s;
      quo_r  <= step_quo_s;
      den_r  <= den;
      cnt_r  <= CW'(DATA_WIDTH - 1);
      done_r <= 1'b0;
    end else if (cnt_r != {CW{1'b0}}) begin
      rem_r  <= step_rem_s;
      quo_r  <= step_quo_s;
      cnt_r  <= cnt_r - CW'(1);
      done_r <= (cnt_r == CW'(1));
    end else begin
      done_r <= 1'b0;
    end
  end

  assign done = done_r;
  assign quo  = quo_r;
  assign rem  = rem_r;

endmodule

// File: rtl/evklid_mod_inv.sv
// -----------------------------------------------------------------------------
// evklid_mod_inv
//   Sequential modular inverse: data_o = data_i^-1 mod gf by iterative extended
//   Euclid. Only the forward Bezout coefficient is tracked, so no quotient
//   stack is needed. Quotients come from the shared multi-cycle divider.
//   Each quotient step costs DATA_WIDTH+2 cycles (CHECK, DIV, UPD).
// Ports
//   clk     in   1           clock, rising edge
//   rst_n   in   1           async active-low reset
//   en      in   1           start request, accepted while busy=0
//   data_i  in   DATA_WIDTH  operand a, sampled with en
//   gf      in   DATA_WIDTH  modulus m, sampled with en
//   busy    out  1           high from accept edge until the rdy pulse
//   rdy     out  1           one-cycle done pulse
//   data_o  out  DATA_WIDTH  inverse in [1,m-1], 0 if not invertible; held
//   gcd_o   out  DATA_WIDTH  final r0 (only with EVKLID_GCD_OUT_EN)
//   err_o   out  1           gcd!=1 or gf<2 (only with EVKLID_GCD_OUT_EN)
// Configuration
//   EVKLID_GCD_OUT_EN : adds gcd_o/err_o, updated together with rdy.
// -----------------------------------------------------------------------------
module evklid_mod_inv
  import evklid_pkg::*;
#(
  parameter int DATA_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [DATA_WIDTH-1:0] gf,
  output logic                  busy,
  output logic                  rdy,
  output logic [DATA_WIDTH-1:0] data_o
`ifdef EVKLID_GCD_OUT_EN
  ,
  output logic [DATA_WIDTH-1:0] gcd_o,
  output logic                  err_o
`endif
);

  localparam int TW = DATA_WIDTH + 1;

  state_t                state_r, state_nxt;
  logic [DATA_WIDTH-1:0] r0_r, r0_nxt;
  logic [DATA_WIDTH-1:0] r1_r, r1_nxt;
  logic [DATA_WIDTH-1:0] gf_r, gf_nxt;
  logic signed [TW-1:0]  t0_r, t0_nxt;
  logic signed [TW-1:0]  t1_r, t1_nxt;
  logic [DATA_WIDTH-1:0] data_nxt;
  logic                  rdy_nxt;
  logic                  busy_nxt;
`ifdef EVKLID_GCD_OUT_EN
  logic [DATA_WIDTH-1:0] gcd_nxt;
  logic                  err_nxt;
`endif

  logic                  div_start_s;
  logic                  div_done_s;
  logic [DATA_WIDTH-1:0] div_quo_s;
  logic [DATA_WIDTH-1:0] div_rem_s;
  logic signed [TW-1:0]  q_ext_s;
  logic signed [TW-1:0]  qt_s;
  logic [DATA_WIDTH-1:0] fix_s;

  evklid_div #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .start (div_start_s),
    .num   (r0_r),
    .den   (r1_r),
    .done  (div_done_s),
    .quo   (div_quo_s),
    .rem   (div_rem_s)
  );

  // Next-state and next-output logic of the Euclid sequencer.
  always_comb begin
    state_nxt   = state_r;
    r0_nxt      = r0_r;
    r1_nxt      = r1_r;
    gf_nxt      = gf_r;
    t0_nxt      = t0_r;
    t1_nxt      = t1_r;
    data_nxt    = data_o;
    rdy_nxt     = 1'b0;
    busy_nxt    = busy;
    div_start_s = 1'b0;
`ifdef EVKLID_GCD_OUT_EN
    gcd_nxt     = gcd_o;
    err_nxt     = err_o;
`endif
    // |t| <= m keeps the product exact modulo 2^TW, so truncation is safe.
    q_ext_s = $signed({1'b0, div_quo_s});
    qt_s    = q_ext_s * t1_r;
    fix_s   = DATA_WIDTH'(fn_mod_fix(32'(t0_r), 32'(gf_r)));

    case (state_r)
      IDLE: begin
        if (en) begin
          r0_nxt   = gf;
          r1_nxt   = data_i;
          gf_nxt   = gf;
          t0_nxt   = {TW{1'b0}};
          t1_nxt   = TW'(1);
          busy_nxt = 1'b1;
          if ((gf < DATA_WIDTH'(2)) || (data_i == {DATA_WIDTH{1'b0}})) begin
            state_nxt = FIX;
          end else begin
            state_nxt = CHECK;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      CHECK: begin
        if (r1_r == {DATA_WIDTH{1'b0}}) begin
          state_nxt = FIX;
        end else begin
          div_start_s = 1'b1;
          state_nxt   = DIV;
        end
      end
      DIV: begin
        if (div_done_s) begin
          state_nxt = UPD;
        end else begin
          state_nxt = DIV;
        end
      end
      UPD: begin
        r0_nxt    = r1_r;
        r1_nxt    = div_rem_s;
        t0_nxt    = t1_r;
        t1_nxt    = t0_r - qt_s;
        state_nxt = CHECK;
      end
      FIX: begin
        // r0 is the gcd; anything other than 1 means no inverse exists.
        if (r0_r == DATA_WIDTH'(1)) begin
          data_nxt = fix_s;
        end else begin
          data_nxt = {DATA_WIDTH{1'b0}};
        end
`ifdef EVKLID_GCD_OUT_EN
        gcd_nxt   = r0_r;
        err_nxt   = (r0_r != DATA_WIDTH'(1)) || (gf_r < DATA_WIDTH'(2));
`endif
        rdy_nxt   = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State, working registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      r0_r    <= {DATA_WIDTH{1'b0}};
      r1_r    <= {DATA_WIDTH{1'b0}};
      gf_r    <= {DATA_WIDTH{1'b0}};
      t0_r    <= {TW{1'b0}};
      t1_r    <= {TW{1'b0}};
      data_o  <= {DATA_WIDTH{1'b0}};
      rdy     <= 1'b0;
      busy    <= 1'b0;
`ifdef EVKLID_GCD_OUT_EN
      gcd_o   <= {DATA_WIDTH{1'b0}};
      err_o   <= 1'b0;
`endif
    end else begin
      state_r <= state_nxt;
      r0_r    <= r0_nxt;
      r1_r    <= r1_nxt;
      gf_r    <= gf_nxt;
      t0_r    <= t0_nxt;
      t1_r    <= t1_nxt;
      data_o  <= data_nxt;
      rdy     <= rdy_nxt;
      busy    <= busy_nxt;
`ifdef EVKLID_GCD_OUT_EN
      gcd_o   <= gcd_nxt;
      err_o   <= err_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_evklid_mod_inv.sv
// -----------------------------------------------------------------------------
// tb_evklid_mod_inv
//   Self-checking bench for evklid_mod_inv (DATA_WIDTH = 6). A reference model
//   derives busy/rdy/data_o from the operands using brute-force inverse search,
//   a textbook gcd and the closed-form latency; a compare process checks the
//   DUT against it every cycle. Directed cases pin the model with literals.
//   With EVKLID_GCD_OUT_EN defined, gcd_o/err_o are checked as well.
// -----------------------------------------------------------------------------
module tb_evklid_mod_inv;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic [W-1:0] data_i = '0;
  logic [W-1:0] gf = '0;
  logic         busy;
  logic         rdy;
  logic [W-1:0] data_o;
`ifdef EVKLID_GCD_OUT_EN
  logic [W-1:0] gcd_o;
  logic         err_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  evklid_mod_inv #(.DATA_WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .data_i (data_i),
    .gf     (gf),
    .busy   (busy),
    .rdy    (rdy),
    .data_o (data_o)
`ifdef EVKLID_GCD_OUT_EN
    ,
    .gcd_o  (gcd_o),
    .err_o  (err_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int m_inv(int a, int m);
    if (m < 2 || a == 0) return 0;
    for (int x = 1; x < m; x++) begin
      if ((a * x) % m == 1) return x;
    end
    return 0;
  endfunction

  function automatic int m_gcd(int a, int m);
    int x, y, t;
    if (m < 2 || a == 0) return m;
    x = m;
    y = a;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic int m_lat(int a, int m);
    int x, y, t, k;
    if (m < 2 || a == 0) return 2;
    x = m;
    y = a;
    k = 0;
    while (y != 0) begin
      k++;
      t = x % y;
      x = y;
      y = t;
    end
    return k * (W + 2) + 3;
  endfunction

  logic m_busy = 1'b0;
  logic m_rdy = 1'b0;
  int   m_data = 0;
  int   m_left = 0;
  int   m_pd = 0;
`ifdef EVKLID_GCD_OUT_EN
  int   m_gcdv = 0;
  int   m_errv = 0;
  int   m_pg = 0;
  int   m_pe = 0;
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_rdy  <= 1'b0;
      m_data <= 0;
      m_left <= 0;
`ifdef EVKLID_GCD_OUT_EN
      m_gcdv <= 0;
      m_errv <= 0;
`endif
    end else begin
      m_rdy <= 1'b0;
      if (!m_busy) begin
        if (en) begin
          m_busy <= 1'b1;
          m_left <= m_lat(int'(data_i), int'(gf)) - 1;
          m_pd   <= m_inv(int'(data_i), int'(gf));
`ifdef EVKLID_GCD_OUT_EN
          m_pg   <= m_gcd(int'(data_i), int'(gf));
          m_pe   <= (m_gcd(int'(data_i), int'(gf)) != 1 || gf < 2) ? 1 : 0;
`endif
        end
      end else begin
        if (m_left == 1) begin
          m_rdy  <= 1'b1;
          m_busy <= 1'b0;
          m_data <= m_pd;
`ifdef EVKLID_GCD_OUT_EN
          m_gcdv <= m_pg;
          m_errv <= m_pe;
`endif
        end
        m_left <= m_left - 1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("busy", {31'd0, busy}, {31'd0, m_busy});
    check("rdy", {31'd0, rdy}, {31'd0, m_rdy});
    check("data_o", 32'(data_o), m_data);
`ifdef EVKLID_GCD_OUT_EN
    check("gcd_o", 32'(gcd_o), m_gcdv);
    check("err_o", {31'd0, err_o}, m_errv);
`endif
  end

  // ---------------- stimulus ----------------
  task automatic run_op(input int a, input int m, input int poke_at,
                        output int d, output int edges, output int busy_cyc);
    bit got;
    got = 1'b0;
    edges = 0;
    busy_cyc = 0;
    data_i = W'(a);
    gf = W'(m);
    en = 1'b1;
    while (!got && edges < 400) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      en = 1'b0;
      if (edges == poke_at) begin
        en = 1'b1;
        data_i = W'(2);
        gf = W'(59);
      end
      if (busy) busy_cyc++;
      if (rdy) got = 1'b1;
    end
    check("rdy_timeout", {31'd0, got}, 32'd1);
    d = int'(data_o);
  endtask

  initial begin
    int d, e, b;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_rdy", {31'd0, rdy}, 32'd0);
    check("reset_data", 32'(data_o), 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    run_op(3, 7, 0, d, e, b);
    check("inv_7_3", d, 5);
    check("lat_7_3", e, 19);
    check("busy_7_3", b, 18);

    run_op(8, 12, 0, d, e, b);
    check("inv_12_8", d, 0);
    check("lat_12_8", e, 19);
`ifdef EVKLID_GCD_OUT_EN
    check("gcd_12_8", 32'(gcd_o), 32'd4);
    check("err_12_8", {31'd0, err_o}, 32'd1);
`endif

    run_op(0, 7, 0, d, e, b);
    check("inv_7_0", d, 0);
    check("lat_7_0", e, 2);

    run_op(5, 1, 0, d, e, b);
    check("inv_1_5", d, 0);
    check("lat_1_5", e, 2);
`ifdef EVKLID_GCD_OUT_EN
    check("err_1_5", {31'd0, err_o}, 32'd1);
`endif

    run_op(10, 7, 0, d, e, b);
    check("inv_7_10", d, 5);
    check("lat_7_10", e, 35);

    run_op(7, 7, 0, d, e, b);
    check("inv_7_7", d, 0);
    check("lat_7_7", e, 11);

    // Back-to-back sweep over the whole field mod 59.
    for (int a = 1; a < 59; a++) begin
      run_op(a, 59, 0, d, e, b);
      check("sweep_prod", (d * a) % 59, 1);
      if (a == 1) check("inv_59_1", d, 1);
    end

    // en pulsed mid-run with different operands must be ignored.
    run_op(3, 7, 5, d, e, b);
    check("poke_inv", d, 5);
    check("poke_lat", e, 19);

    // Reset in the middle of an operation.
    data_i = W'(2);
    gf = W'(59);
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_rdy", {31'd0, rdy}, 32'd0);
    check("midrst_data", 32'(data_o), 32'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    run_op(3, 7, 0, d, e, b);
    check("after_rst_inv", d, 5);
    check("after_rst_lat", e, 19);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
